// File: rtl/pwm_capture_if.sv
// Capture-side bundle: enable and PWM line in, measurement results and status out.
// The master modport drives the PWM line and enable; the slave modport is the capture block.
interface pwm_capture_if #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned PCNT_W = 28
);
   logic              Start_En_Sig;
   logic              pwm_in;
   logic [CNT_W-1:0]  high_time;
   logic [CNT_W-1:0]  period;
   logic              meas_valid;
   logic [PCNT_W-1:0] pulse_count;
   logic              busy;
   logic              ovf;
   logic              Done_Sig;

   modport master (
      output Start_En_Sig, pwm_in,
      input  high_time, period, meas_valid, pulse_count, busy, ovf, Done_Sig
   );

   modport slave (
      input  Start_En_Sig, pwm_in,
      output high_time, period, meas_valid, pulse_count, busy, ovf, Done_Sig
   );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of each pulse on an asynchronous PWM line,
// counts pulses in a burst and flags end of burst after TIMEOUT quiet cycles.
module pwm_capture #(
   parameter int unsigned     CNT_W   = 16,
   parameter int unsigned     PCNT_W  = 28,
   parameter logic [CNT_W-1:0] TIMEOUT = 16'd1000
) (
   input logic          clk,
   input logic          reset,
   pwm_capture_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      MEASURE,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

   state_t            state_q;
   logic              syncMeta_q;
   logic              syncOut_q;
   logic              hist_q;
   logic              armedLow_q;
   logic              hiRun_q;
   logic [CNT_W-1:0]  perCnt_q;
   logic [CNT_W-1:0]  hiCnt_q;
   logic [CNT_W-1:0]  highTime_q;
   logic [CNT_W-1:0]  period_q;
   logic [PCNT_W-1:0] pulseCount_q;
   logic              measValid_q;
   logic              busy_q;
   logic              ovf_q;
   logic              done_q;

   logic              rise;
   logic              fall;

   // Two flops tame metastability; the third holds the previous synchronized level for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncMeta_q <= 1'b0;
         syncOut_q  <= 1'b0;
         hist_q     <= 1'b0;
      end else begin
         syncMeta_q <= bus.pwm_in;
         syncOut_q  <= syncMeta_q;
         hist_q     <= syncOut_q;
      end
   end

   assign rise = syncOut_q & ~hist_q;
   assign fall = ~syncOut_q & hist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         armedLow_q   <= 1'b0;
         hiRun_q      <= 1'b0;
         perCnt_q     <= '0;
         hiCnt_q      <= '0;
         highTime_q   <= '0;
         period_q     <= '0;
         pulseCount_q <= '0;
         measValid_q  <= 1'b0;
         busy_q       <= 1'b0;
         ovf_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         measValid_q <= 1'b0;
         if (!bus.Start_En_Sig) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q      <= WAIT_FIRST;
                  busy_q       <= 1'b1;
                  pulseCount_q <= '0;
                  ovf_q        <= 1'b0;
                  armedLow_q   <= 1'b0;
               end

               // A line already high at arming must go low before its next rise counts.
               WAIT_FIRST: begin
                  if (!syncOut_q) begin
                     armedLow_q <= 1'b1;
                  end
                  if (rise && armedLow_q) begin
                     state_q      <= MEASURE;
                     pulseCount_q <= PCNT_W'(1);
                     perCnt_q     <= CNT_W'(1);
                     hiCnt_q      <= CNT_W'(1);
                     hiRun_q      <= 1'b1;
                  end
               end

               MEASURE: begin
                  if (rise) begin
                     period_q    <= perCnt_q;
                     measValid_q <= 1'b1;
                     if (hiRun_q) begin
                        highTime_q <= hiCnt_q;
                     end
                     perCnt_q <= CNT_W'(1);
                     hiCnt_q  <= CNT_W'(1);
                     hiRun_q  <= 1'b1;
                     if (pulseCount_q == PCNT_MAX) begin
                        ovf_q <= 1'b1;
                     end else begin
                        pulseCount_q <= pulseCount_q + PCNT_W'(1);
                     end
                  end else begin
                     if (fall && hiRun_q) begin
                        highTime_q <= hiCnt_q;
                        hiRun_q    <= 1'b0;
                     end
                     if (perCnt_q == CNT_MAX) begin
                        ovf_q <= 1'b1;
                     end else begin
                        perCnt_q <= perCnt_q + CNT_W'(1);
                     end
                     if (hiRun_q) begin
                        if (hiCnt_q == CNT_MAX) begin
                           ovf_q <= 1'b1;
                        end else begin
                           hiCnt_q <= hiCnt_q + CNT_W'(1);
                        end
                     end
                     if (perCnt_q == TIMEOUT) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end

               DONE: begin
                  done_q <= 1'b1;
               end

               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.high_time   = highTime_q;
   assign bus.period      = period_q;
   assign bus.meas_valid  = measValid_q;
   assign bus.pulse_count = pulseCount_q;
   assign bus.busy        = busy_q;
   assign bus.ovf         = ovf_q;
   assign bus.Done_Sig    = done_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a nominal 16-bit instance and an 8-bit saturation instance,
// both compared every cycle against a timestamp-based behavioural model.
module tb_pwm_capture;

   localparam int PMAX = 268435455;

   typedef struct {
      int st;
      bit sh1;
      bit sh2;
      bit hist;
      bit armedLow;
      bit fallSeen;
      int cyc;
      int tRise;
      int highTime;
      int period;
      int pc;
      bit mv;
      bit busy;
      bit ovf;
      bit done;
   } model_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   int passCount = 0;
   int checkCount = 0;
   int cycleNo = 0;
   int measCount = 0;
   int rise5Cycle = 0;
   int doneCycle = 0;
   int prevPc = 0;
   bit prevDone = 1'b0;
   bit nominalPhase = 1'b0;
   int measBefore;

   model_t m0;
   model_t m1;

   always #10 clk = ~clk;

   pwm_capture_if #(.CNT_W(16), .PCNT_W(28)) bus0 ();
   pwm_capture_if #(.CNT_W(8),  .PCNT_W(28)) bus1 ();

   pwm_capture #(.CNT_W(16), .PCNT_W(28), .TIMEOUT(16'd1000)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   pwm_capture #(.CNT_W(8), .PCNT_W(28), .TIMEOUT(8'd255)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic model_t modelClear();
      model_t n;
      n = '{default: 0};
      return n;
   endfunction

   // Elapsed cycles since the last accepted rise stand in for the hardware counters.
   function automatic model_t modelStep(model_t s, bit en, bit pin, int mx, int tmo);
      model_t n;
      bit     sync;
      bit     rise;
      bit     fall;
      int     el;
      int     sel;
      n    = s;
      sync = s.sh2;
      rise = s.sh2 && !s.hist;
      fall = !s.sh2 && s.hist;
      el   = s.cyc - s.tRise;
      sel  = (el > mx) ? mx : el;
      n.mv = 1'b0;
      if (!en) begin
         n.st   = 0;
         n.busy = 1'b0;
         n.done = 1'b0;
      end else if (s.st == 0) begin
         n.st       = 1;
         n.busy     = 1'b1;
         n.pc       = 0;
         n.ovf      = 1'b0;
         n.armedLow = 1'b0;
      end else if (s.st == 1) begin
         if (!sync) n.armedLow = 1'b1;
         if (rise && s.armedLow) begin
            n.st       = 2;
            n.pc       = 1;
            n.tRise    = s.cyc;
            n.fallSeen = 1'b0;
         end
      end else if (s.st == 2) begin
         if (rise) begin
            n.period = sel;
            if (!s.fallSeen) n.highTime = sel;
            n.mv       = 1'b1;
            n.tRise    = s.cyc;
            n.fallSeen = 1'b0;
            if (s.pc == PMAX) n.ovf = 1'b1;
            else n.pc = s.pc + 1;
         end else begin
            if (fall && !s.fallSeen) begin
               n.highTime = sel;
               n.fallSeen = 1'b1;
            end
            if (el >= mx) n.ovf = 1'b1;
            if (sel == tmo) begin
               n.st   = 3;
               n.busy = 1'b0;
               n.done = 1'b1;
            end
         end
      end
      n.hist = s.sh2;
      n.sh2  = s.sh1;
      n.sh1  = pin;
      n.cyc  = s.cyc + 1;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m0 = modelClear();
         m1 = modelClear();
      end else begin
         m0 = modelStep(m0, bus0.Start_En_Sig, bus0.pwm_in, 65535, 1000);
         m1 = modelStep(m1, bus1.Start_En_Sig, bus1.pwm_in, 255, 255);
      end
   end

   // Every cycle, both instances are held against the model.
   always @(negedge clk) begin
      checkOutput("d0_high_time",   32'(bus0.high_time),   m0.highTime);
      checkOutput("d0_period",      32'(bus0.period),      m0.period);
      checkOutput("d0_meas_valid",  32'(bus0.meas_valid),  32'(m0.mv));
      checkOutput("d0_pulse_count", 32'(bus0.pulse_count), m0.pc);
      checkOutput("d0_busy",        32'(bus0.busy),        32'(m0.busy));
      checkOutput("d0_ovf",         32'(bus0.ovf),         32'(m0.ovf));
      checkOutput("d0_done",        32'(bus0.Done_Sig),    32'(m0.done));
      checkOutput("d1_high_time",   32'(bus1.high_time),   m1.highTime);
      checkOutput("d1_period",      32'(bus1.period),      m1.period);
      checkOutput("d1_meas_valid",  32'(bus1.meas_valid),  32'(m1.mv));
      checkOutput("d1_pulse_count", 32'(bus1.pulse_count), m1.pc);
      checkOutput("d1_busy",        32'(bus1.busy),        32'(m1.busy));
      checkOutput("d1_ovf",         32'(bus1.ovf),         32'(m1.ovf));
      checkOutput("d1_done",        32'(bus1.Done_Sig),    32'(m1.done));
   end

   always @(negedge clk) begin
      cycleNo++;
      if (bus0.meas_valid) begin
         measCount++;
         if (nominalPhase) begin
            checkOutput("nom_strobe_high",   32'(bus0.high_time), 181);
            checkOutput("nom_strobe_period", 32'(bus0.period),    246);
         end
      end
      if (32'(bus0.pulse_count) == 5 && prevPc != 5) rise5Cycle = cycleNo;
      if (bus0.Done_Sig && !prevDone) doneCycle = cycleNo;
      prevPc   = 32'(bus0.pulse_count);
      prevDone = bus0.Done_Sig;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic setPin(input bit sel, input bit v);
      if (sel) bus1.pwm_in = v;
      else bus0.pwm_in = v;
   endtask

   task automatic applyStimulus(input bit sel, input int nPulses, input int highCyc, input int perCyc);
      for (int p = 0; p < nPulses; p++) begin
         setPin(sel, 1'b1);
         tick(highCyc);
         setPin(sel, 1'b0);
         tick(perCyc - highCyc);
      end
   endtask

   task automatic waitDone(input bit sel, input int budget, input string name);
      int n;
      n = 0;
      while (n < budget && !(sel ? bus1.Done_Sig : bus0.Done_Sig)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(sel ? bus1.Done_Sig : bus0.Done_Sig), 1);
   endtask

   initial begin
      bus0.Start_En_Sig = 1'b0;
      bus0.pwm_in       = 1'b0;
      bus1.Start_En_Sig = 1'b0;
      bus1.pwm_in       = 1'b0;
      reset             = 1'b1;

      $display("[TB] reset with toggling line");
      for (int i = 0; i < 10; i++) begin
         bus0.pwm_in = i[0];
         bus1.pwm_in = i[0];
         tick(1);
      end
      checkOutput("rst_pulse_count", 32'(bus0.pulse_count), 0);
      checkOutput("rst_busy",        32'(bus0.busy),        0);
      checkOutput("rst_done",        32'(bus0.Done_Sig),    0);
      checkOutput("rst_high_time",   32'(bus0.high_time),   0);
      bus0.pwm_in = 1'b0;
      bus1.pwm_in = 1'b0;
      reset       = 1'b0;
      tick(10);
      checkOutput("idle_busy", 32'(bus0.busy), 0);

      $display("[TB] nominal burst");
      bus0.Start_En_Sig = 1'b1;
      tick(5);
      measCount    = 0;
      nominalPhase = 1'b1;
      applyStimulus(1'b0, 5, 181, 246);
      waitDone(1'b0, 1500, "nom_done_reached");
      tick(1);
      nominalPhase = 1'b0;
      checkOutput("nom_strobe_count", measCount, 4);
      checkOutput("nom_pulse_count",  32'(bus0.pulse_count), 5);
      checkOutput("nom_done_latency", doneCycle - rise5Cycle, 1000);
      checkOutput("nom_ovf",          32'(bus0.ovf), 0);
      checkOutput("nom_last_high",    32'(bus0.high_time), 181);

      $display("[TB] line high at arming");
      bus0.Start_En_Sig = 1'b0;
      tick(3);
      bus0.pwm_in = 1'b1;
      tick(5);
      bus0.Start_En_Sig = 1'b1;
      tick(50);
      bus0.pwm_in = 1'b0;
      tick(20);
      applyStimulus(1'b0, 3, 30, 80);
      waitDone(1'b0, 1500, "lh_done_reached");
      tick(1);
      checkOutput("lh_pulse_count", 32'(bus0.pulse_count), 3);
      checkOutput("lh_high_time",   32'(bus0.high_time),   30);

      $display("[TB] saturation on 8-bit instance");
      bus1.Start_En_Sig = 1'b1;
      tick(5);
      applyStimulus(1'b1, 2, 100, 300);
      waitDone(1'b1, 400, "sat_done_reached");
      tick(1);
      checkOutput("sat_ovf",         32'(bus1.ovf),         1);
      checkOutput("sat_pulse_count", 32'(bus1.pulse_count), 1);
      checkOutput("sat_high_time",   32'(bus1.high_time),   100);
      checkOutput("sat_period",      32'(bus1.period),      0);
      bus1.Start_En_Sig = 1'b0;

      $display("[TB] abort mid-burst");
      bus0.Start_En_Sig = 1'b0;
      tick(3);
      bus0.Start_En_Sig = 1'b1;
      tick(5);
      applyStimulus(1'b0, 2, 20, 50);
      checkOutput("abort_pulse_count", 32'(bus0.pulse_count), 2);
      measBefore        = measCount;
      bus0.Start_En_Sig = 1'b0;
      tick(1);
      checkOutput("abort_busy", 32'(bus0.busy), 0);
      applyStimulus(1'b0, 2, 20, 50);
      tick(1100);
      checkOutput("abort_done",    32'(bus0.Done_Sig), 0);
      checkOutput("abort_no_meas", measCount, measBefore);
      bus0.Start_En_Sig = 1'b1;
      tick(1);
      checkOutput("rearm_pulse_count", 32'(bus0.pulse_count), 0);
      checkOutput("rearm_busy",        32'(bus0.busy),        1);

      $display("[TB] done handshake");
      tick(5);
      applyStimulus(1'b0, 3, 40, 100);
      waitDone(1'b0, 1500, "hs_done_reached");
      applyStimulus(1'b0, 5, 40, 100);
      checkOutput("hs_done_held",   32'(bus0.Done_Sig),    1);
      checkOutput("hs_pulse_count", 32'(bus0.pulse_count), 3);
      checkOutput("hs_high_time",   32'(bus0.high_time),   40);
      checkOutput("hs_period",      32'(bus0.period),      100);
      bus0.Start_En_Sig = 1'b0;
      tick(1);
      checkOutput("hs_done_cleared", 32'(bus0.Done_Sig), 0);

      $display("[TB] reset mid-capture");
      bus0.Start_En_Sig = 1'b1;
      tick(5);
      applyStimulus(1'b0, 2, 20, 50);
      #5;
      reset = 1'b1;
      #1;
      checkOutput("midrst_busy",        32'(bus0.busy),        0);
      checkOutput("midrst_pulse_count", 32'(bus0.pulse_count), 0);
      checkOutput("midrst_period",      32'(bus0.period),      0);
      checkOutput("midrst_high_time",   32'(bus0.high_time),   0);
      tick(2);
      bus0.Start_En_Sig = 1'b0;
      reset             = 1'b0;
      tick(3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the motor PWM burst generator.
- Samples an incoming PWM line and measures each pulse's high time and period in clk cycles.
- Counts pulses in a burst and raises Done_Sig when the line goes quiet.
- Used in loopback self-test of the H-bridge drive path and for capturing externally supplied PWM commands.

Parameters:
- CNT_W, 16: width of the high-time and period measurement counters (saturating).
- PCNT_W, 28: width of the pulse counter (saturating).
- TIMEOUT, 16'd1000: clk cycles after the most recent accepted rising edge with no new rising edge; reaching it declares end of burst.

Ports:
- clk  input  1  system clock, 49.152 MHz.
- reset  input  1  asynchronous, active-high reset.
- Start_En_Sig  input  1  level enable; high arms and runs the capture, low returns to idle.
- pwm_in  input  1  asynchronous PWM line.
- high_time  output  CNT_W  last measured high duration, in clk cycles.
- period  output  CNT_W  last measured rise-to-rise distance, in clk cycles.
- meas_valid  output  1  one-cycle strobe; high_time/period hold a complete pair.
- pulse_count  output  PCNT_W  accepted rising edges since arming.
- busy  output  1  high in WAIT_FIRST or MEASURE.
- ovf  output  1  sticky; a counter saturated since arming.
- Done_Sig  output  1  burst finished; held until Start_En_Sig drops.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, synchronizer and history flops 0.
- Input path:
  - pwm_in passes a 2-flop synchronizer plus one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - An edge is detected 3 clk cycles after the pin transition. All measurements are relative to detected edges, so latency cancels.
- States:
  - IDLE:
    - busy=0, Done_Sig=0; high_time/period/pulse_count keep their last values.
    - Start_En_Sig=1 -> WAIT_FIRST. On this transition clear pulse_count and ovf, and clear armed_low.
  - WAIT_FIRST:
    - armed_low is set by any cycle with sync=0. A rise is accepted only when armed_low=1, so a line already high at arming is ignored until it falls.
    - Accepted rise -> MEASURE; pulse_count=1; per_cnt=1; hi_cnt=1; hi_run=1.
    - No timeout in this state.
  - MEASURE, each cycle:
    - per_cnt increments, saturating at all-ones. Saturation sets ovf.
    - hi_cnt increments while hi_run=1, saturating (sets ovf).
    - fall with hi_run=1: high_time<=hi_cnt; hi_run<=0.
    - rise: period<=per_cnt; meas_valid=1 in the same cycle. high_time then holds this pulse's value (a pulse whose fall was not yet seen gives high_time<=hi_cnt at this rise). Then per_cnt<=1, hi_cnt<=1, hi_run<=1, and pulse_count increments (saturating; sets ovf).
    - per_cnt==TIMEOUT with no rise in that cycle -> DONE. A rise in the same cycle wins.
    - The final pulse of a burst latches high_time on its fall but never produces meas_valid.
  - DONE:
    - Done_Sig=1, busy=0; outputs frozen.
    - Start_En_Sig=0 -> IDLE, Done_Sig cleared next cycle.
- Start_En_Sig=0 in any state -> IDLE next cycle. Any partial measurement is discarded and meas_valid is not produced.
- Asserting reset mid-capture returns to IDLE immediately, with all outputs 0.
- meas_valid is never high in two consecutive cycles.
- Minimum resolvable high or low phase: 1 clk cycle after synchronization. Glitches shorter than one clk cycle may be lost; this is acceptable.

Test Plan:
- Reset sequencing: assert reset with pwm_in toggling -> all outputs 0. Release reset, Start_En_Sig=0 -> state remains IDLE, busy=0.
- Nominal burst: Start_En_Sig=1; 5 pulses, high 181 cycles, period 246 cycles ->
  - 4 meas_valid strobes, each with high_time=181, period=246;
  - pulse_count=5;
  - Done_Sig=1 exactly 1000 cycles after the 5th detected rise;
  - ovf=0.
- Line high at arming: pwm_in=1 when Start_En_Sig rises, falls after 50 cycles, then 3 normal pulses -> pulse_count=3; the first partial pulse is not counted.
- Saturation: set CNT_W=8, TIMEOUT=8'd255; send period 300, high 100 -> per_cnt saturates at 255 and ovf=1. Reaching 255 equals TIMEOUT, so DONE is entered after the first pulse with pulse_count=1.
- Abort: drop Start_En_Sig mid-burst after 2 pulses -> busy=0 next cycle, no further meas_valid, Done_Sig stays 0. Re-arming clears pulse_count to 0.
- Done handshake: hold Start_En_Sig=1 for 500 cycles after Done_Sig and send extra pulses -> outputs unchanged, Done_Sig stays 1. Drop enable -> Done_Sig=0 one cycle later.
